cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Cache miss-fill controller: produces the stall_data_miss that freezes IF_ID/ID_EX/EX_MEM/MEM_WB.
//  On a cache miss it holds the stall and fetches the whole block from multi-cycle main memory.
//  It issues reads in order, writes each returned word into the cache data array, then writes the tag.
//  One instance serves the I-cache and one serves the D-cache; arbitration between them lies outside this block.
// PARAMETERS
//  WORDS     8   16-bit words per cache block (power of 2; block = 2*WORDS bytes)
//  MEM_LAT   4   cycles from memory_read_en to the matching memory_data_valid (fixed, pipelined)
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   asynchronous reset, active-high
//  miss_detected       in   1   cache lookup missed this cycle (level)
//  miss_address        in   16  byte address of the missing access
//  memory_data_valid   in   1   memory_data carries a returned word
//  memory_data         in   16  word returned by memory
//  fsm_busy            out  1   stall; drives stall_data_miss of all pipeline registers
//  memory_read_en      out  1   issue a read of memory_address this cycle
//  memory_address      out  16  byte address of the word being requested
//  write_data_array    out  1   write fill_data into data array at word_index
//  word_index          out  log2(WORDS)  word offset inside block for the current write
//  fill_data           out  16  = memory_data (combinational pass-through)
//  write_tag_array     out  1   write tag/valid for miss block (one cycle pulse)
// BEHAVIOUR
//  States: IDLE, FILL. Registers: base[15:0], issue_cnt (0..WORDS), recv_cnt (0..WORDS-1).
//  Reset (async, any time): state=IDLE, base=0, counters=0. While reset is held, fsm_busy,
//   memory_read_en, write_data_array and write_tag_array are 0, and memory_address=0.
//  IDLE: fsm_busy = miss_detected (combinational, so the pipeline stalls in the miss cycle).
//   If miss_detected=1: base <= miss_address with the low log2(2*WORDS) bits cleared,
//   counters <= 0, next state FILL. memory_data_valid is ignored in IDLE: no writes occur.
//  FILL: fsm_busy=1.
//   memory_read_en = (issue_cnt < WORDS).
//   memory_address = base + 2*issue_cnt. The add is 16 bits, but base alignment means no carry out of the block.
//   issue_cnt increments on each issue.
//   On memory_data_valid: write_data_array=1, word_index=recv_cnt, and recv_cnt increments (wraps to 0).
//   On the valid with recv_cnt==WORDS-1: write_tag_array=1 in the same cycle, next state IDLE.
//   Issue and receive may coincide in a cycle; the two counters are independent.
//   miss_detected and miss_address are ignored during FILL.
//  Latency (defaults): miss in cycle 0; issues in cycles 1-8; data in cycles 5-12; tag write in cycle 12.
//   fsm_busy is high in cycles 0-12 (13 cycles). In cycle 13 the state is IDLE again.
//  Back-to-back: a miss asserted in cycle 13 starts a new fill immediately (busy is not deasserted in between).
//  Outside FILL: write_data_array, write_tag_array and memory_read_en are 0. memory_address=base.
//  Reset mid-fill aborts: no tag write; partially written words stay, but the tag stays invalid.
//   Valids still in flight after the reset are ignored (state is IDLE).
//  fill_data = memory_data at all times; the consumer qualifies it with write_data_array.
// TESTING
//  1. Miss at 0x1236, memory model with 4-cycle latency -> reads 0x1230,0x1232..0x123E in cycles 1-8.
//     Writes idx0..7 in cycles 5-12. write_tag_array pulses only in cycle 12; fsm_busy high for exactly 13 cycles.
//  2. Miss at 0xFFFF -> addresses 0xFFF0..0xFFFE; no wrap to 0x0000; tag write occurs.
//  3. miss_detected held high through the whole fill -> no restart, no extra reads.
//     After the tag write, a miss seen in the first IDLE cycle starts the second fill at once.
//  4. rst pulsed in cycle 6 of a fill -> outputs 0 immediately, no tag write.
//     The remaining valids do not cause writes; a later miss performs a full clean 8-word fill.
//  5. memory_data_valid pulses while IDLE with no miss -> write_data_array stays 0 and fsm_busy stays 0.
//  6. Pipeline integration: lw miss -> IF_ID through MEM_WB hold their contents for 13 cycles.
//     The load then retires with the word at miss_address (e.g. 0xBEEF) written to its Rd.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache miss-fill controller: stalls the pipeline on a miss and refills the whole block
// from fixed-latency pipelined memory, writing each returned word and then the tag.
module cache_fill_ctrl #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [15:0]              miss_address,
    input  logic                     memory_data_valid,
    input  logic [15:0]              memory_data,
    output logic                     fsm_busy,
    output logic                     memory_read_en,
    output logic [15:0]              memory_address,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] word_index,
    output logic [15:0]              fill_data,
    output logic                     write_tag_array
);
    // state | meaning
    // IDLE  | no fill in progress; busy follows miss_detected so the miss cycle already stalls
    // FILL  | issuing block reads and writing returned words until the last word lands

    localparam int IDX_W = $clog2(WORDS);
    localparam int OFF_W = $clog2(2 * WORDS);

    localparam logic [IDX_W:0]   ISSUE_MAX = (IDX_W + 1)'(WORDS);
    localparam logic [IDX_W:0]   ISSUE_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] RECV_LAST = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] RECV_ONE  = IDX_W'(1);

    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
        $error("cache_fill_ctrl: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_base;
    logic [IDX_W:0]   r_issue_cnt;
    logic [IDX_W-1:0] r_recv_cnt;

    logic             w_issue;
    logic             w_recv;
    logic             w_last;
    logic [15:0]      w_offset;

    // Issue and receive counters advance independently; overlap is the normal case.
    assign w_issue  = (r_state == FILL) && (r_issue_cnt < ISSUE_MAX);
    assign w_recv   = (r_state == FILL) && memory_data_valid;
    assign w_last   = w_recv && (r_recv_cnt == RECV_LAST);
    assign w_offset = 16'(r_issue_cnt) << 1;

    assign fill_data = memory_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                if (miss_detected) begin
                    r_base      <= {miss_address[15:OFF_W], {OFF_W{1'b0}}};
                    r_issue_cnt <= '0;
                    r_recv_cnt  <= '0;
                end
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + ISSUE_ONE;
                end
                if (w_recv) begin
                    r_recv_cnt <= r_recv_cnt + RECV_ONE;
                end
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = r_base;
        write_data_array = 1'b0;
        word_index       = r_recv_cnt;
        write_tag_array  = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so a miss seen while reset is held cannot raise the stall.
                fsm_busy = miss_detected & ~rst;
                if (miss_detected) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                memory_read_en   = w_issue;
                memory_address   = r_base + w_offset;
                write_data_array = w_recv;
                write_tag_array  = w_last;
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a fixed-latency memory model answers the reads, and each
// fill is compared cycle by cycle with the timeline implied by the miss cycle.
module tb_cache_fill_ctrl;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;
    localparam int IDX_W   = $clog2(WORDS);

    logic             clk = 1'b0;
    logic             rst;
    logic             miss_detected;
    logic [15:0]      miss_address;
    logic             memory_data_valid;
    logic [15:0]      memory_data;
    logic             fsm_busy;
    logic             memory_read_en;
    logic [15:0]      memory_address;
    logic             write_data_array;
    logic [IDX_W-1:0] word_index;
    logic [15:0]      fill_data;
    logic             write_tag_array;

    cache_fill_ctrl #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_index        (word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    rd_t         pend[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    bit          beef_en;
    logic [15:0] beef_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (beef_en && a == beef_addr) return 16'hBEEF;
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    // One clock cycle: drive inputs at the falling edge, let combinational outputs settle,
    // then let the memory model accept any read issued this cycle.
    task automatic drive_cycle(input logic miss, input logic [15:0] maddr);
        @(negedge clk);
        miss_detected     = miss;
        miss_address      = maddr;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        if (memory_read_en) pend.push_back('{cyc + MEM_LAT, memory_address});
        cyc++;
    endtask

    // A fill started by a miss at step k=0; expected activity follows from k alone.
    task automatic fill_and_check(input logic [15:0] a, input bit hold_miss, input string name);
        logic [15:0]      base;
        logic [3:0]       exp_v;
        logic [3:0]       obs_v;
        logic [15:0]      exp_addr;
        logic [IDX_W-1:0] exp_idx;
        logic [15:0]      exp_data;
        base = a & ~16'(2 * WORDS - 1);
        for (int k = 0; k <= WORDS + MEM_LAT; k++) begin
            drive_cycle(hold_miss || k == 0, (k == 0) ? a : 16'($urandom));
            exp_v = {1'b1, (k >= 1 && k <= WORDS), (k > MEM_LAT && k <= WORDS + MEM_LAT),
                     (k == WORDS + MEM_LAT)};
            obs_v = {fsm_busy, memory_read_en, write_data_array, write_tag_array};
            n_checks++;
            if (obs_v !== exp_v)
                $display("FAIL %s ctrl k=%0d: busy/rd/wr/tag got %b want %b", name, k, obs_v, exp_v);
            else n_pass++;
            if (exp_v[2]) begin
                exp_addr = base + 16'(2 * (k - 1));
                n_checks++;
                if (memory_address !== exp_addr)
                    $display("FAIL %s addr k=%0d: got %h want %h", name, k, memory_address, exp_addr);
                else n_pass++;
            end
            if (exp_v[1]) begin
                exp_idx  = IDX_W'(k - MEM_LAT - 1);
                exp_data = mem_word(base + 16'(2 * (k - MEM_LAT - 1)));
                n_checks++;
                if ({word_index, fill_data} !== {exp_idx, exp_data})
                    $display("FAIL %s write k=%0d: idx/data got %0d/%h want %0d/%h",
                             name, k, word_index, fill_data, exp_idx, exp_data);
                else n_pass++;
            end
        end
    endtask

    task automatic check_idle(input logic [15:0] exp_base, input string name);
        drive_cycle(1'b0, 16'($urandom));
        n_checks++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array, memory_address} !==
            {4'b0000, exp_base})
            $display("FAIL %s idle: busy/rd/wr/tag=%b addr=%h want 0000 addr=%h", name,
                     {fsm_busy, memory_read_en, write_data_array, write_tag_array},
                     memory_address, exp_base);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        miss_detected     = 1'b1;
        miss_address      = 16'h1234;
        memory_data_valid = 1'b1;
        memory_data       = 16'hC0DE;
        #2;
        n_checks++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000)
            $display("FAIL reset ctrl: got %b want 0000",
                     {fsm_busy, memory_read_en, write_data_array, write_tag_array});
        else n_pass++;
        n_checks++;
        if (memory_address !== 16'h0000)
            $display("FAIL reset addr: got %h want 0000", memory_address);
        else n_pass++;
        n_checks++;
        if (fill_data !== 16'hC0DE)
            $display("FAIL reset fill_data passthrough: got %h want c0de", fill_data);
        else n_pass++;
        @(negedge clk);
        rst               = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        cyc               = 0;
    endtask

    task automatic test_basic_fill();
        fill_and_check(16'h1236, 1'b0, "fill_1236");
        check_idle(16'h1230, "fill_1236");
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            fill_and_check(a, 1'b0, "fill_rand");
            check_idle(a & ~16'(2 * WORDS - 1), "fill_rand");
        end
    endtask

    task automatic test_top_boundary();
        fill_and_check(16'hFFFF, 1'b0, "top_ffff");
        check_idle(16'hFFF0, "top_ffff");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a2;
        a2 = 16'($urandom);
        fill_and_check(16'h4A10, 1'b1, "b2b_first");
        fill_and_check(a2, 1'b0, "b2b_second");
        check_idle(a2 & ~16'(2 * WORDS - 1), "b2b_second");
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] a;
        a = 16'($urandom);
        for (int k = 0; k < 6; k++) drive_cycle(k == 0, a);
        drive_cycle(1'b0, 16'($urandom));
        rst = 1'b1;
        #1;
        n_checks++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array, memory_address} !== 20'h0)
            $display("FAIL midrst immediate: ctrl=%b addr=%h want 0000 addr=0000",
                     {fsm_busy, memory_read_en, write_data_array, write_tag_array}, memory_address);
        else n_pass++;
        drive_cycle(1'b0, 16'($urandom));
        n_checks++;
        if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000)
            $display("FAIL midrst held: busy/wr/tag got %b want 000",
                     {fsm_busy, write_data_array, write_tag_array});
        else n_pass++;
        rst = 1'b0;
        for (int g = 0; g < 10 && pend.size() > 0; g++) begin
            drive_cycle(1'b0, 16'($urandom));
            n_checks++;
            if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000)
                $display("FAIL midrst late valid: ctrl got %b want 0000",
                         {fsm_busy, memory_read_en, write_data_array, write_tag_array});
            else n_pass++;
        end
        check_idle(16'h0000, "midrst");
        a = 16'($urandom);
        fill_and_check(a, 1'b0, "midrst_refill");
        check_idle(a & ~16'(2 * WORDS - 1), "midrst_refill");
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 4; i++) begin
            pend.push_back('{cyc, 16'h0040 + 16'(2 * i)});
            drive_cycle(1'b0, 16'($urandom));
            n_checks++;
            if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000)
                $display("FAIL idle_valid: ctrl got %b want 0000",
                         {fsm_busy, memory_read_en, write_data_array, write_tag_array});
            else n_pass++;
        end
    endtask

    task automatic test_pipeline();
        logic [15:0] dcache[WORDS];
        logic [15:0] lw_addr;
        logic [15:0] rd_val;
        int          stall;
        bit          tag_seen;
        lw_addr   = 16'h2A4C;
        beef_en   = 1'b1;
        beef_addr = lw_addr;
        stall     = 0;
        tag_seen  = 1'b0;
        for (int i = 0; i < WORDS; i++) dcache[i] = 16'h0000;
        for (int c = 0; c < 40; c++) begin
            drive_cycle(c == 0, lw_addr);
            if (fsm_busy) stall++;
            if (write_data_array) dcache[word_index] = fill_data;
            if (write_tag_array) tag_seen = 1'b1;
            if (tag_seen && !fsm_busy) break;
        end
        rd_val = dcache[(lw_addr >> 1) % WORDS];
        n_checks++;
        if (!tag_seen) $display("FAIL pipe tag: no tag write within 40 cycles, want one");
        else n_pass++;
        n_checks++;
        if (stall != WORDS + MEM_LAT + 1)
            $display("FAIL pipe stall: held %0d cycles want %0d", stall, WORDS + MEM_LAT + 1);
        else n_pass++;
        n_checks++;
        if (rd_val !== 16'hBEEF) $display("FAIL pipe load: Rd got %h want beef", rd_val);
        else n_pass++;
        beef_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        beef_en  = 1'b0;
        cyc      = 0;
        test_reset();
        test_basic_fill();
        test_top_boundary();
        test_back_to_back();
        test_reset_mid_fill();
        test_idle_valid();
        test_pipeline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
